// File: rtl/sata_phy_if_mc.sv
// Multi-lane SATA PHY interface: TX ALIGN insertion, RX comma realignment, link-up qualification.
// One sata_phy_if_mc_lane per SATA port; all lanes share phyclk and phyreset.
module sata_phy_if_mc_lane #(
  parameter int ALIGN_INTERVAL = 256,
  parameter int LINKUP_ALIGNS  = 3
) (
  input  logic        phyclk,
  input  logic        phyreset,
  input  logic        phy_ready,
  input  logic [31:0] txdata,
  input  logic        txdatak,
  output logic        txdatak_pop,
  output logic [31:0] txdata_fis,
  output logic [3:0]  tx_charisk_fis,
  input  logic [31:0] rxdata_fis,
  input  logic [3:0]  rxcharisk,
  output logic        linkup,
  output logic [31:0] phy2cs_data,
  output logic        phy2cs_k,
  output logic        phy2cs_valid,
  output logic        rx_err
);
  localparam int SCW = $clog2(ALIGN_INTERVAL);
  localparam int CW  = $clog2(LINKUP_ALIGNS + 1);
  localparam logic [31:0] ALIGN_D = 32'h7B4A4ABC;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
  } rx_word_t;

  typedef enum logic [1:0] {DOWN, WAIT_ALIGN, UP} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  acnt, acnt_nxt;
  logic [SCW-1:0] sc;
  rx_word_t       raw, r1, alw;
  logic           shift;
  logic           al_is_align;
  logic           tx_pass;

  assign raw = {rxdata_fis, rxcharisk};

  // shift=1: comma sat in byte 2, so the dword spans the upper half of r1 and lower half of raw
  always_comb begin
    alw = r1;
    if (shift) begin
      alw.d = {raw.d[15:0], r1.d[31:16]};
      alw.k = {raw.k[1:0], r1.k[3:2]};
    end
  end

  assign al_is_align = (alw.d == ALIGN_D) && (alw.k == 4'b0001);

  always_comb begin
    state_nxt = state;
    acnt_nxt  = acnt;
    case (state)
      DOWN: if (phy_ready) begin
        state_nxt = WAIT_ALIGN;
        acnt_nxt  = '0;
      end
      WAIT_ALIGN: begin
        if (!phy_ready) state_nxt = DOWN;
        else if (al_is_align) begin
          acnt_nxt = acnt + 1'b1;
          if (acnt == CW'(LINKUP_ALIGNS - 1)) state_nxt = UP;
        end else acnt_nxt = '0;
      end
      UP: if (!phy_ready) state_nxt = DOWN;
      default: state_nxt = DOWN;
    endcase
  end

  // last two slots of every interval are reserved for ALIGN
  assign tx_pass     = linkup && (sc < SCW'(ALIGN_INTERVAL - 2));
  assign txdatak_pop = tx_pass;

  always_ff @(posedge phyclk) begin
    if (phyreset) begin
      state          <= DOWN;
      acnt           <= '0;
      linkup         <= 1'b0;
      sc             <= '0;
      txdata_fis     <= ALIGN_D;
      tx_charisk_fis <= 4'b0001;
      r1             <= '0;
      shift          <= 1'b0;
      phy2cs_data    <= '0;
      phy2cs_k       <= 1'b0;
      phy2cs_valid   <= 1'b0;
      rx_err         <= 1'b0;
    end else begin
      state  <= state_nxt;
      acnt   <= acnt_nxt;
      linkup <= (state_nxt == UP);
      sc     <= linkup ? sc + 1'b1 : '0;
      if (tx_pass) begin
        txdata_fis     <= txdata;
        tx_charisk_fis <= {3'b000, txdatak};
      end else begin
        txdata_fis     <= ALIGN_D;
        tx_charisk_fis <= 4'b0001;
      end
      r1 <= raw;
      if (raw.k == 4'b0001 && raw.d[7:0] == 8'hBC)        shift <= 1'b0;
      else if (raw.k == 4'b0100 && raw.d[23:16] == 8'hBC) shift <= 1'b1;
      phy2cs_data  <= alw.d;
      phy2cs_k     <= alw.k[0];
      phy2cs_valid <= linkup && !al_is_align;
      rx_err       <= linkup && (alw.k[3:1] != 3'b000);
    end
  end
endmodule

module sata_phy_if_mc #(
  parameter int C_NUM_CHANNELS   = 2,
  parameter int C_ALIGN_INTERVAL = 256,
  parameter int C_LINKUP_ALIGNS  = 3
) (
  input  logic                                phyclk,
  input  logic                                phyreset,
  input  logic [C_NUM_CHANNELS-1:0]           phy_ready,
  input  logic [C_NUM_CHANNELS-1:0][31:0]     txdata,
  input  logic [C_NUM_CHANNELS-1:0]           txdatak,
  output logic [C_NUM_CHANNELS-1:0]           txdatak_pop,
  output logic [C_NUM_CHANNELS-1:0][31:0]     txdata_fis,
  output logic [C_NUM_CHANNELS-1:0][3:0]      tx_charisk_fis,
  input  logic [C_NUM_CHANNELS-1:0][31:0]     rxdata_fis,
  input  logic [C_NUM_CHANNELS-1:0][3:0]      rxcharisk,
  output logic [C_NUM_CHANNELS-1:0]           linkup,
  output logic [C_NUM_CHANNELS-1:0][31:0]     phy2cs_data,
  output logic [C_NUM_CHANNELS-1:0]           phy2cs_k,
  output logic [C_NUM_CHANNELS-1:0]           phy2cs_valid,
  output logic [C_NUM_CHANNELS-1:0]           rx_err
);
  for (genvar i = 0; i < C_NUM_CHANNELS; i++) begin : g_lane
    sata_phy_if_mc_lane #(
      .ALIGN_INTERVAL (C_ALIGN_INTERVAL),
      .LINKUP_ALIGNS  (C_LINKUP_ALIGNS)
    ) u_lane (
      .phyclk         (phyclk),
      .phyreset       (phyreset),
      .phy_ready      (phy_ready[i]),
      .txdata         (txdata[i]),
      .txdatak        (txdatak[i]),
      .txdatak_pop    (txdatak_pop[i]),
      .txdata_fis     (txdata_fis[i]),
      .tx_charisk_fis (tx_charisk_fis[i]),
      .rxdata_fis     (rxdata_fis[i]),
      .rxcharisk      (rxcharisk[i]),
      .linkup         (linkup[i]),
      .phy2cs_data    (phy2cs_data[i]),
      .phy2cs_k       (phy2cs_k[i]),
      .phy2cs_valid   (phy2cs_valid[i]),
      .rx_err         (rx_err[i])
    );
  end
endmodule

// File: tb/tb_sata_phy_if_mc.sv
// Directed bench for sata_phy_if_mc: link-up, TX ALIGN cadence, RX realignment, drop and reset.
module tb_sata_phy_if_mc;
  localparam int N = 2;
  localparam logic [31:0] ALIGN = 32'h7B4A4ABC;

  logic                phyclk = 1'b0;
  logic                phyreset;
  logic [N-1:0]        phy_ready;
  logic [N-1:0][31:0]  txdata;
  logic [N-1:0]        txdatak;
  logic [N-1:0]        txdatak_pop;
  logic [N-1:0][31:0]  txdata_fis;
  logic [N-1:0][3:0]   tx_charisk_fis;
  logic [N-1:0][31:0]  rxdata_fis;
  logic [N-1:0][3:0]   rxcharisk;
  logic [N-1:0]        linkup;
  logic [N-1:0][31:0]  phy2cs_data;
  logic [N-1:0]        phy2cs_k;
  logic [N-1:0]        phy2cs_valid;
  logic [N-1:0]        rx_err;

  always #5 phyclk = ~phyclk;

  sata_phy_if_mc #(.C_NUM_CHANNELS(N), .C_ALIGN_INTERVAL(256), .C_LINKUP_ALIGNS(3)) dut (
    .phyclk(phyclk), .phyreset(phyreset), .phy_ready(phy_ready),
    .txdata(txdata), .txdatak(txdatak), .txdatak_pop(txdatak_pop),
    .txdata_fis(txdata_fis), .tx_charisk_fis(tx_charisk_fis),
    .rxdata_fis(rxdata_fis), .rxcharisk(rxcharisk), .linkup(linkup),
    .phy2cs_data(phy2cs_data), .phy2cs_k(phy2cs_k),
    .phy2cs_valid(phy2cs_valid), .rx_err(rx_err)
  );

  int n_chk = 0;
  int n_err = 0;
  bit up_m = 1'b0;
  int sc_m = 0;
  logic [31:0] data_v;
  logic [31:0] tw_d [5];
  logic [3:0]  tw_k [5];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one clock; sc_m tracks the slot counter the lane should hold while linked
  task automatic step();
    @(posedge phyclk);
    #1;
    if (up_m) sc_m = (sc_m + 1) % 256;
    else      sc_m = 0;
  endtask

  task automatic rx(input logic [31:0] d, input logic [3:0] k);
    rxdata_fis[0] = d;
    rxcharisk[0]  = k;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_fis"},  txdata_fis[0], ALIGN);
    chk({tag, "_chk"},  tx_charisk_fis[0], 32'h1);
    chk({tag, "_pop"},  txdatak_pop, 32'h0);
    chk({tag, "_lk"},   linkup, 32'h0);
    chk({tag, "_vld"},  phy2cs_valid, 32'h0);
    chk({tag, "_err"},  rx_err, 32'h0);
    chk({tag, "_dat"},  phy2cs_data[0], 32'h0);
    chk({tag, "_k"},    phy2cs_k, 32'h0);
    chk({tag, "_fis1"}, txdata_fis[1], ALIGN);
  endtask

  initial begin
    phyreset = 1'b1; phy_ready = '0; txdata = '0; txdatak = '0;
    rxdata_fis = '0; rxcharisk = '0;
    step(); step();
    chk_reset("rst");
    phyreset = 1'b0;

    // link-up on lane 0 only
    data_v = 32'hA000_0000;
    txdata[0] = data_v; txdatak[0] = data_v[0];
    phy_ready[0] = 1'b1;
    rx(32'h12345678, 4'h0);
    step();
    rx(ALIGN, 4'b0001);
    step(); step(); step();
    chk("lk_early", linkup, 32'h0);
    chk("pop_down", txdatak_pop, 32'h0);
    step();
    chk("linkup", linkup, 32'h1);
    up_m = 1'b1; sc_m = 0;

    // two full ALIGN intervals of TX traffic
    for (int k = 0; k < 512; k++) begin
      logic exp_pop;
      exp_pop = (sc_m < 254);
      chk("tx_pop", {31'b0, txdatak_pop[0]}, {31'b0, exp_pop});
      step();
      if (exp_pop) begin
        chk("tx_data", txdata_fis[0], data_v);
        chk("tx_k", tx_charisk_fis[0], {31'b0, data_v[0]});
        data_v = data_v + 1;
        txdata[0] = data_v; txdatak[0] = data_v[0];
      end else begin
        chk("tx_align", txdata_fis[0], ALIGN);
        chk("tx_align_k", tx_charisk_fis[0], 32'h1);
      end
    end
    chk("tx_count", data_v - 32'hA000_0000, 32'd508);
    chk("rx_align_vld", phy2cs_valid, 32'h0);

    // comma in byte 2: ALIGN and DEADBEEF rebuilt across word boundaries
    rx(32'h4ABC1111, 4'b0100); step();
    rx(32'hBEEF7B4A, 4'b0000); step();
    chk("sh_align", phy2cs_data[0], ALIGN);
    chk("sh_align_k", phy2cs_k, 32'h1);
    chk("sh_align_v", phy2cs_valid, 32'h0);
    rx(32'h1234DEAD, 4'b0000); step();
    chk("sh_data", phy2cs_data[0], 32'hDEADBEEF);
    chk("sh_data_v", phy2cs_valid, 32'h1);
    chk("sh_data_k", phy2cs_k, 32'h0);
    chk("sh_data_e", rx_err, 32'h0);
    rx(ALIGN, 4'b0001); step();
    chk("straddle", phy2cs_data[0], 32'h4ABC1234);
    chk("straddle_e", rx_err, 32'h1);
    rx(32'hCAFEF00D, 4'b0000); step();
    chk("sh0_align", phy2cs_data[0], ALIGN);
    chk("sh0_align_v", phy2cs_valid, 32'h0);
    chk("sh0_align_e", rx_err, 32'h0);
    step();
    chk("sh0_data", phy2cs_data[0], 32'hCAFEF00D);
    chk("sh0_data_v", phy2cs_valid, 32'h1);

    // ALIGN interleaved with data and other primitives
    tw_d[0] = 32'hB5B5957C; tw_k[0] = 4'b0001;
    tw_d[1] = ALIGN;        tw_k[1] = 4'b0001;
    tw_d[2] = 32'h11223344; tw_k[2] = 4'b0000;
    tw_d[3] = ALIGN;        tw_k[3] = 4'b0001;
    tw_d[4] = 32'h55667788; tw_k[4] = 4'b0000;
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) rx(tw_d[i], tw_k[i]);
      step();
      if (i > 0) begin
        chk("il_data", phy2cs_data[0], tw_d[i-1]);
        chk("il_k", {31'b0, phy2cs_k[0]}, {31'b0, tw_k[i-1][0]});
        chk("il_vld", {31'b0, phy2cs_valid[0]}, (tw_d[i-1] == ALIGN && tw_k[i-1] == 4'b0001) ? 32'h0 : 32'h1);
      end
    end

    // charisk on a non-zero byte lane
    rx(32'h00000055, 4'b0010); step();
    rx(32'h00000066, 4'b0000); step();
    chk("err_pulse", rx_err, 32'h1);
    chk("err_lk", linkup, 32'h1);
    step();
    chk("err_clear", rx_err, 32'h0);
    chk("err_lk2", linkup, 32'h1);

    // drop phy_ready at slot 100
    for (int g = 0; g < 300 && sc_m != 100; g++) step();
    chk("sc100_pop", txdatak_pop, 32'h1);
    phy_ready[0] = 1'b0;
    step();
    up_m = 1'b0;
    chk("drop_lk", linkup, 32'h0);
    chk("drop_pop", txdatak_pop, 32'h0);
    step();
    chk("drop_fis", txdata_fis[0], ALIGN);
    chk("drop_chk", tx_charisk_fis[0], 32'h1);
    chk("drop_pop2", txdatak_pop, 32'h0);
    chk("drop_vld", phy2cs_valid, 32'h0);

    // relink: the slot counter must restart from zero
    phy_ready[0] = 1'b1;
    step();
    rx(ALIGN, 4'b0001);
    step(); step(); step(); step();
    chk("relink", linkup, 32'h1);
    up_m = 1'b1; sc_m = 0;
    for (int g = 0; g < 300 && sc_m != 253; g++) step();
    chk("relink_pop253", txdatak_pop, 32'h1);
    step();
    chk("relink_pop254", txdatak_pop, 32'h0);

    // reset pulse mid-operation
    rx(32'h99999999, 4'b0000);
    step(); step();
    chk("pre_rst_dat", phy2cs_data[0], 32'h99999999);
    phyreset = 1'b1;
    step();
    up_m = 1'b0;
    chk_reset("rst2");
    phyreset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
